// File: rtl/pulse_meas_pkg.sv
// rtl/pulse_meas_pkg.sv - shared types for the pulse measurement stage
package pulse_meas_pkg;

    localparam int PM_CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        PM_IDLE,
        PM_ARMED,
        PM_HIGH,
        PM_LOW
    } pm_state_e;

    // Bit layout matches the flat result vector produced by pulse_meas_obuf.
    typedef struct packed {
        logic [PM_CNT_WIDTH_DEF-1:0] high;
        logic [PM_CNT_WIDTH_DEF-1:0] period;
        logic                        ovf;
        logic                        lost;
    } pm_res_t;

endpackage

// File: rtl/pulse_meas_obuf.sv
// rtl/pulse_meas_obuf.sv - single-entry valid/ready result register with drop and sticky-lost
import pulse_meas_pkg::*;

module pulse_meas_obuf #(
    parameter int W = PM_CNT_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [2*W:0]   in_res,
    input  logic           ready,
    output logic           valid,
    output logic [2*W+1:0] res
);

    logic lost_sticky;
    logic free;

    assign free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            res         <= '0;
            lost_sticky <= 1'b0;
        end else if (load && free) begin
            valid       <= 1'b1;
            res         <= {in_res, lost_sticky};
            lost_sticky <= 1'b0;
        end else begin
            // A result arriving while the entry is held is dropped and remembered.
            if (load) begin
                lost_sticky <= 1'b1;
            end
            if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pulse_meas.sv
// rtl/pulse_meas.sv - high-time and period measurement from synchronised edge pulses
import pulse_meas_pkg::*;

module pulse_meas #(
    parameter int CNT_WIDTH = PM_CNT_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 re_i,
    input  logic                 fe_i,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 ovf_o,
    output logic                 lost_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    pm_state_e            state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] high_q;
    logic                 ovf_q;
    logic                 cnt_sat;
    logic                 emit;
    logic [2*CNT_WIDTH+1:0] obuf_res;

    assign cnt_sat = (cnt == CNT_MAX);
    assign emit    = en_i && (state == PM_LOW) && re_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= PM_IDLE;
            cnt    <= '0;
            high_q <= '0;
            ovf_q  <= 1'b0;
        end else if (!en_i) begin
            state <= PM_IDLE;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                PM_IDLE: state <= PM_ARMED;
                PM_ARMED: begin
                    if (re_i) begin
                        state <= PM_HIGH;
                        cnt   <= CNT_ONE;
                        ovf_q <= 1'b0;
                    end
                end
                PM_HIGH, PM_LOW: begin
                    // Any rising edge restarts: closes a period in LOW, aborts in HIGH.
                    if (re_i) begin
                        state <= PM_HIGH;
                        cnt   <= CNT_ONE;
                        ovf_q <= 1'b0;
                    end else begin
                        if (state == PM_HIGH && fe_i) begin
                            high_q <= cnt;
                            state  <= PM_LOW;
                        end
                        if (cnt_sat) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: state <= PM_IDLE;
            endcase
        end
    end

    pulse_meas_obuf #(
        .W(CNT_WIDTH)
    ) u_obuf (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (emit),
        .in_res ({high_q, cnt, ovf_q | cnt_sat}),
        .ready  (ready_i),
        .valid  (valid_o),
        .res    (obuf_res)
    );

    generate
        if (CNT_WIDTH == PM_CNT_WIDTH_DEF) begin : g_pkg_res
            pm_res_t res;
            assign res      = obuf_res;
            assign high_o   = res.high;
            assign period_o = res.period;
            assign ovf_o    = res.ovf;
            assign lost_o   = res.lost;
        end else begin : g_flat_res
            assign high_o   = obuf_res[2*CNT_WIDTH+1:CNT_WIDTH+2];
            assign period_o = obuf_res[CNT_WIDTH+1:2];
            assign ovf_o    = obuf_res[1];
            assign lost_o   = obuf_res[0];
        end
    endgenerate

endmodule

// File: tb/tb_pulse_meas.sv
// tb/tb_pulse_meas.sv - directed bench for pulse_meas at CNT_WIDTH 16 and 4
module tb_pulse_meas;

    logic clk = 1'b0;
    logic rst, en, re, fe, ready;

    logic [15:0] h16, p16;
    logic        o16, l16, v16;
    logic [3:0]  h4, p4;
    logic        o4, l4, v4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_meas #(.CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .re_i(re), .fe_i(fe),
        .high_o(h16), .period_o(p16), .ovf_o(o16), .lost_o(l16),
        .valid_o(v16), .ready_i(ready)
    );

    pulse_meas #(.CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .re_i(re), .fe_i(fe),
        .high_o(h4), .period_o(p4), .ovf_o(o4), .lost_o(l4),
        .valid_o(v4), .ready_i(ready)
    );

    // Event-time model: a result is the edge-time differences, clipped to the counter range.
    int  now;
    int  m_mode [2];
    int  m_t0 [2];
    int  m_t1 [2];
    bit  m_fs [2];
    bit  m_v [2];
    int  m_h [2];
    int  m_p [2];
    bit  m_o [2];
    bit  m_l [2];
    bit  m_sticky [2];
    int  m_max [2];

    initial begin : compare
        int  ah, ap;
        bit  av, ao, al;
        bit  emit;
        int  eh, ep;
        bit  eo;
        now = 0;
        m_max[0] = 65535;
        m_max[1] = 15;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_t0[i] = 0; m_t1[i] = 0; m_fs[i] = 0; m_v[i] = 0;
            m_h[i] = 0; m_p[i] = 0; m_o[i] = 0; m_l[i] = 0; m_sticky[i] = 0;
        end
        forever begin
            @(negedge clk);
            now++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_mode[i] = 0; m_fs[i] = 0; m_v[i] = 0; m_h[i] = 0;
                    m_p[i] = 0; m_o[i] = 0; m_l[i] = 0; m_sticky[i] = 0;
                end
                if (i == 0) begin
                    av = v16; ah = int'(h16); ap = int'(p16); ao = o16; al = l16;
                end else begin
                    av = v4; ah = int'(h4); ap = int'(p4); ao = o4; al = l4;
                end
                n_checks++;
                if (av !== m_v[i] || ah != m_h[i] || ap != m_p[i] || ao !== m_o[i] || al !== m_l[i]) begin
                    n_fail++;
                    $display("FAIL model cyc%0d inst%0d: valid/high/period/ovf/lost got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                             now, i, av, ah, ap, ao, al, m_v[i], m_h[i], m_p[i], m_o[i], m_l[i]);
                end
                if (!rst) begin
                    emit = 1'b0;
                    eh = 0; ep = 0; eo = 1'b0;
                    if (!en) begin
                        m_mode[i] = 0;
                    end else if (m_mode[i] == 0) begin
                        m_mode[i] = 1;
                    end else if (m_mode[i] == 1) begin
                        if (re) begin
                            m_t0[i] = now; m_fs[i] = 0; m_mode[i] = 2;
                        end
                    end else begin
                        if (re) begin
                            if (m_fs[i]) begin
                                emit = 1'b1;
                                eh = (m_t1[i] - m_t0[i] > m_max[i]) ? m_max[i] : m_t1[i] - m_t0[i];
                                ep = (now - m_t0[i] > m_max[i]) ? m_max[i] : now - m_t0[i];
                                eo = (now - m_t0[i]) >= m_max[i];
                            end
                            m_t0[i] = now; m_fs[i] = 0;
                        end else if (fe && !m_fs[i]) begin
                            m_t1[i] = now; m_fs[i] = 1;
                        end
                    end
                    if (emit && (!m_v[i] || ready)) begin
                        m_v[i] = 1; m_h[i] = eh; m_p[i] = ep; m_o[i] = eo;
                        m_l[i] = m_sticky[i]; m_sticky[i] = 0;
                    end else begin
                        if (emit) m_sticky[i] = 1;
                        if (ready) m_v[i] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_re();
        re = 1'b1; step(); re = 1'b0;
    endtask

    task automatic pulse_fe();
        fe = 1'b1; step(); fe = 1'b0;
    endtask

    task automatic rearm();
        en = 1'b0; step();
        en = 1'b1; step();
    endtask

    task automatic period8();
        idle(3); pulse_fe(); idle(3); pulse_re();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; en = 1'b0; re = 1'b0; fe = 1'b0; ready = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset_valid", v16, 0);
        chk("reset_high", h16, 0);
        chk("reset_period", p16, 0);
        chk("reset_lost", l16, 0);

        // Basic measurement: re 10, fe 15, re 30.
        en = 1'b1; ready = 1'b1;
        step();
        pulse_re(); idle(4); pulse_fe(); idle(14); pulse_re();
        chk("t1_valid", v16, 1);
        chk("t1_high", h16, 5);
        chk("t1_period", p16, 20);
        chk("t1_ovf", o16, 0);
        chk("t1_lost", l16, 0);

        // Saturation in the 4-bit instance: re 0, fe 3, re 40.
        rearm();
        pulse_re(); idle(2); pulse_fe(); idle(36); pulse_re();
        chk("t2_valid4", v4, 1);
        chk("t2_period4", p4, 15);
        chk("t2_high4", h4, 3);
        chk("t2_ovf4", o4, 1);
        chk("t2_period16", p16, 40);
        chk("t2_ovf16", o16, 0);

        // Back-pressure: first result held, next two dropped.
        rearm();
        ready = 1'b0;
        pulse_re(); period8();
        chk("t3_first_valid", v16, 1);
        chk("t3_first_period", p16, 8);
        period8(); period8();
        chk("t3_held_high", h16, 4);
        chk("t3_held_lost", l16, 0);
        ready = 1'b1;
        period8();
        chk("t3_next_lost", l16, 1);
        chk("t3_next_period", p16, 8);
        period8();
        chk("t3_after_lost", l16, 0);

        // Leading fe ignored; re while high aborts and restarts.
        rearm();
        pulse_fe(); idle(4); pulse_re(); idle(7); pulse_re(); idle(1); pulse_fe(); idle(5);
        chk("t4_no_abort_result", v16, 0);
        pulse_re();
        chk("t4_valid", v16, 1);
        chk("t4_high", h16, 2);
        chk("t4_period", p16, 8);

        // Enable dropped mid-high: no result from the aborted measurement.
        idle(3);
        en = 1'b0; idle(5);
        en = 1'b1; idle(5);
        chk("t5_no_result", v16, 0);
        pulse_re(); pulse_fe(); idle(1); pulse_re();
        chk("t5_high", h16, 1);
        chk("t5_period", p16, 3);

        // Asynchronous reset while a result is held.
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", v16, 0);
        chk("t6_rst_high", h16, 0);
        chk("t6_rst_period", p16, 0);
        chk("t6_rst_valid4", v4, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready = 1'b1;
        step();
        pulse_re(); idle(2); pulse_fe(); idle(3); pulse_re();
        chk("t6_resume_valid", v16, 1);
        chk("t6_resume_high", h16, 3);
        chk("t6_resume_period", p16, 7);
        chk("t6_resume_lost", l16, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
